// File: rtl/moore_pkg.sv
// Shared types and constants for the overlapping "101" Moore sequence detector.
package moore_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned PATTERN_W = 3;

    // Exposed so benches can model the match without restating the bit string.
    localparam logic [PATTERN_W-1:0] PATTERN = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        S101 = 2'b11
    } state_t;

endpackage

// File: rtl/moore.sv
// Moore FSM that flags each overlapping occurrence of "101" on a serial input.
module moore
    import moore_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic data_out
);

    state_t state;
    state_t state_next;

    // The state register holds the only storage; reset forces S0 asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = data_in ? S1   : S0;
            S1:      state_next = data_in ? S1   : S10;
            S10:     state_next = data_in ? S101 : S0;
            // The trailing "1" of a match seeds the next match.
            S101:    state_next = data_in ? S1   : S10;
            default: state_next = S0;
        endcase
    end

    // data_out depends only on the current state, so data_in never reaches it combinationally.
    always_comb begin
        data_out = 1'b0;
        if (state == S101) begin
            data_out = 1'b1;
        end
    end

endmodule

// File: tb/tb_moore.sv
// Self-checking bench for moore: directed scenarios plus randomized stream against a history model.
module tb_moore;
    import moore_pkg::*;

    logic clk;
    logic rst;
    logic data_in;
    logic data_out;

    int vectors;
    int miscompares;

    // Model: the last three bits seen since reset, and how many bits (capped at 3) have been seen.
    logic [2:0] last3;
    int         nbits;

    moore dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_out();
        return (nbits >= 3) && (last3 == PATTERN);
    endfunction

    // Caller is positioned just after a rising edge; drive, clock once, settle, update model.
    task automatic step(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
        if (!rst) begin
            nbits = 0;
            last3 = 3'b000;
        end else begin
            last3 = {last3[1:0], b};
            if (nbits < 3) nbits++;
        end
    endtask

    task automatic apply_reset();
        rst   = 1'b0;
        nbits = 0;
        last3 = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        nbits = 0;
        last3 = 3'b000;
        for (int i = 0; i < 2; i++) begin
            data_in = ~data_in;
            #2;
            vectors++;
            if (data_out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_cycle%0d: data_out=%b required 0", i, data_out);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (data_out !== 1'b0 || dut.state !== S0) begin
                miscompares++;
                $display("FAIL reset_edge%0d: data_out=%b state=%0d required 0 / S0",
                         i, data_out, dut.state);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0] bits;
        logic [4:0] expv;
        bits = 5'b01010;   // applied MSB first: 0,1,0,1,0
        expv = 5'b00010;
        apply_reset();
        for (int i = 4; i >= 0; i--) begin
            step(bits[i]);
            vectors++;
            if (data_out !== expv[i]) begin
                miscompares++;
                $display("FAIL basic_edge%0d: data_out=%b required %b", 5 - i, data_out, expv[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [4:0] bits;
        logic [4:0] expv;
        bits = 5'b10101;
        expv = 5'b00101;
        apply_reset();
        for (int i = 4; i >= 0; i--) begin
            step(bits[i]);
            vectors++;
            if (data_out !== expv[i]) begin
                miscompares++;
                $display("FAIL overlap_edge%0d: data_out=%b required %b", 5 - i, data_out, expv[i]);
            end
        end
    endtask

    task automatic test_nonmatch();
        logic [5:0] bits;
        bits = 6'b110011;
        apply_reset();
        for (int i = 5; i >= 0; i--) begin
            step(bits[i]);
            vectors++;
            if (data_out !== 1'b0) begin
                miscompares++;
                $display("FAIL nonmatch_edge%0d: data_out=%b required 0", 6 - i, data_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1'b1);
        step(1'b0);
        rst   = 1'b0;
        nbits = 0;
        last3 = 3'b000;
        data_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1);
        vectors++;
        if (data_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_prefix_lost: data_out=%b required 0", data_out);
        end
        step(1'b0);
        vectors++;
        if (data_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after_10: data_out=%b required 0", data_out);
        end
        step(1'b1);
        vectors++;
        if (data_out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_full_match: data_out=%b required 1", data_out);
        end
    endtask

    task automatic test_async();
        apply_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        vectors++;
        if (data_out !== 1'b1) begin
            miscompares++;
            $display("FAIL async_precondition: data_out=%b required 1", data_out);
        end
        #2;
        rst   = 1'b0;
        nbits = 0;
        last3 = 3'b000;
        #1;
        vectors++;
        if (data_out !== 1'b0) begin
            miscompares++;
            $display("FAIL async_drop: data_out=%b required 0 before next edge", data_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (data_out !== 1'b0) begin
            miscompares++;
            $display("FAIL async_hold: data_out=%b required 0", data_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic prev;
        apply_reset();
        prev = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                apply_reset();
                prev = 1'b0;
            end
            step(1'($urandom_range(0, 1)));
            vectors++;
            if (data_out !== model_out() || (prev && data_out)) begin
                miscompares++;
                $display("FAIL random_step%0d: data_out=%b required %b (prev=%b, last3=%b)",
                         i, data_out, model_out(), prev, last3);
            end
            prev = data_out;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nbits       = 0;
        last3       = 3'b000;
        rst         = 1'b0;
        data_in     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overlap();
        test_nonmatch();
        test_reset_mid();
        test_async();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/moore.md
MOORE -- requirements
Module: moore

Interface
REQ-001 Parameters: none; pattern "101", overlap enabled, 2-bit state encoding fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 data_in  input  1  serial bit stream, sampled on each rising clk edge.
REQ-005 data_out  output  1  detect flag; 1 while FSM is in state S101.

Function
REQ-006 Moore FSM SHALL have four states:
- S0: idle / no prefix.
- S1: "1" seen.
- S10: "10" seen.
- S101: full match.
REQ-007 Transitions on rising clk edge, taking data_in=0 / data_in=1:
- S0 -> S0 / S1
- S1 -> S10 / S1
- S10 -> S0 / S101
- S101 -> S10 / S1
REQ-008 Detection SHALL be overlapping:
- the final "1" of a match SHALL count as the first "1" of the next match;
- "10101" yields two detects.
REQ-009 data_out SHALL be a function of current state only (1 in S101, 0 elsewhere); no combinational path from data_in to data_out.
REQ-010 Latency: data_out SHALL rise on the same rising edge that samples the final "1" and stay high exactly one clock period unless a new match completes.
REQ-011 A new match cannot complete on the edge immediately after S101, so data_out pulses SHALL always be one cycle wide, separated by at least one low cycle.
REQ-012 Next-state logic SHALL be combinational; state register SHALL be the only storage.
REQ-013 Any unreachable encoding SHALL transition to S0 on the next edge, with data_out=0.
REQ-014 Simultaneous reset and edge: reset SHALL win.

Reset
REQ-015 While rst=0, state SHALL be forced to S0 asynchronously and data_out SHALL be 0, independent of clk.
REQ-016 After rst returns to 1, the first rising edge SHALL evaluate data_in from S0; partial prefixes from before reset SHALL be lost.
REQ-017 Reset asserted mid-sequence (e.g. after "10") SHALL discard the prefix, so a following "1" alone SHALL NOT detect.

Structure
REQ-018 A shared package SHALL hold:
- state type (S0=2'b00, S1=2'b01, S10=2'b10, S101=2'b11);
- pattern constant "101" for bench reuse.
REQ-019 Single module with three blocks: state register, next-state logic, output decode; no sub-module required.

Verification
REQ-020 Reset: rst=0 for two cycles with data_in toggling -> data_out=0 throughout, state S0.
REQ-021 Basic match: after reset, data_in 0,1,0,1,0 on consecutive edges -> data_out=0,0,0,1,0 (high only after the 4th edge).
REQ-022 Overlap: data_in 1,0,1,0,1 -> data_out high after edges 3 and 5 only, each pulse one cycle.
REQ-023 Non-match: data_in 1,1,0,0,1,1 -> data_out stays 0.
REQ-024 Reset mid-sequence: data_in 1,0, then rst=0 one cycle, then rst=1 and data_in 1 -> data_out stays 0; continuing 0,1 -> data_out=1 after the final edge.
REQ-025 Async check: assert rst=0 between edges while data_out=1 -> data_out falls to 0 immediately, before the next clk edge.
